// File: rtl/aes_word_ctrl.sv
// Word-serial wrapper around a 128-bit cipher core: gathers four input words, loads the core,
// then streams the result back as four words. Define AES_WORD_CTRL_WDOG_EN to abort a hung core.
module aes_word_ctrl #(
  parameter int unsigned WD_CYCLES = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [31:0]  out_data,
  input  logic         out_ready,
  output logic         core_ld,
  output logic [127:0] core_key,
  output logic [127:0] core_text_in,
  input  logic         core_done,
  input  logic [127:0] core_text_out,
  input  logic         err_clr,
  output logic         err,
  output logic         busy
);

  typedef enum logic [1:0] {StFill, StLoad, StWait, StDrain} state_e;

  state_e       state_q, state_d;
  logic [1:0]   wcnt_q, wcnt_d;
  logic [127:0] ibuf_q, ibuf_d;
  logic [127:0] obuf_q, obuf_d;
  logic [127:0] text_q, text_d;
  logic [127:0] key_q, key_d;
  logic [31:0]  out_data_q, out_data_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         core_ld_q, core_ld_d;
  logic         in_hs, out_hs;

  // Word 0 lives in the most significant 32 bits.
  function automatic logic [31:0] word_sel(input logic [127:0] b, input logic [1:0] i);
    logic [31:0] w;
    unique case (i)
      2'd0:    w = b[127:96];
      2'd1:    w = b[95:64];
      2'd2:    w = b[63:32];
      default: w = b[31:0];
    endcase
    return w;
  endfunction

`ifdef AES_WORD_CTRL_WDOG_EN
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
  logic       err_set;
`else
  logic       unused_err_clr;
  logic [7:0] unused_wd_cycles;
  assign unused_err_clr   = err_clr;
  assign unused_wd_cycles = 8'(WD_CYCLES);
`endif

  assign in_hs = in_valid & in_ready_q & (state_q == StFill);
  assign out_hs = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ibuf_d  = ibuf_q;
    obuf_d  = obuf_q;
    text_d  = text_q;
    key_d   = key_q;
`ifdef AES_WORD_CTRL_WDOG_EN
    wd_d    = wd_q;
    err_set = 1'b0;
`endif
    unique case (state_q)
      StFill: begin
        if (in_hs) begin
          unique case (wcnt_q)
            2'd0:    ibuf_d[127:96] = in_data;
            2'd1:    ibuf_d[95:64]  = in_data;
            2'd2:    ibuf_d[63:32]  = in_data;
            default: ibuf_d[31:0]   = in_data;
          endcase
          if (wcnt_q == 2'd3) begin
            text_d  = {ibuf_q[127:32], in_data};
            key_d   = key;
            wcnt_d  = 2'd0;
            state_d = StLoad;
          end else begin
            wcnt_d = wcnt_q + 2'd1;
          end
        end
      end
      StLoad: begin
        state_d = StWait;
`ifdef AES_WORD_CTRL_WDOG_EN
        wd_d = 8'd0;
`endif
      end
      StWait: begin
        if (core_done) begin
          obuf_d  = core_text_out;
          state_d = StDrain;
        end
`ifdef AES_WORD_CTRL_WDOG_EN
        else if (wd_q == 8'(WD_CYCLES - 1)) begin
          err_set = 1'b1;
          wcnt_d  = 2'd0;
          state_d = StFill;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      default: begin
        if (out_hs) begin
          if (wcnt_q == 2'd3) begin
            wcnt_d  = 2'd0;
            state_d = StFill;
          end else begin
            wcnt_d = wcnt_q + 2'd1;
          end
        end
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    in_ready_d  = (state_d == StFill);
    out_valid_d = (state_d == StDrain);
    core_ld_d   = (state_d == StLoad);
    out_data_d  = out_valid_d ? word_sel(obuf_d, wcnt_d) : out_data_q;
`ifdef AES_WORD_CTRL_WDOG_EN
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StFill;
      wcnt_q      <= 2'd0;
      ibuf_q      <= '0;
      obuf_q      <= '0;
      text_q      <= '0;
      key_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      core_ld_q   <= 1'b0;
`ifdef AES_WORD_CTRL_WDOG_EN
      wd_q        <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ibuf_q      <= ibuf_d;
      obuf_q      <= obuf_d;
      text_q      <= text_d;
      key_q       <= key_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      core_ld_q   <= core_ld_d;
`ifdef AES_WORD_CTRL_WDOG_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign core_ld      = core_ld_q;
  assign core_key     = key_q;
  assign core_text_in = text_q;
  assign busy         = !((state_q == StFill) && (wcnt_q == 2'd0));
`ifdef AES_WORD_CTRL_WDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_word_ctrl.sv
// Directed bench for aes_word_ctrl: FIPS-197 vector, output stall, gapped input, reset mid-block,
// stray core_done, and watchdog (or no-watchdog) behaviour.
module tb_aes_word_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key = '0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_ready = 1'b0;
  logic         core_ld;
  logic [127:0] core_key;
  logic [127:0] core_text_in;
  logic         core_done = 1'b0;
  logic [127:0] core_text_out = '0;
  logic         err_clr = 1'b0;
  logic         err;
  logic         busy;

  int total = 0;
  int bad = 0;
  int ld_cnt = 0;
  int ld_mark;

  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Key2    = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] Pt2     = 128'h11111111222222223333333344444444;
  localparam logic [127:0] Ct2     = 128'hdeadbeefcafebabe0123456789abcdef;

  aes_word_ctrl #(.WD_CYCLES(31)) dut (
    .clk          (clk),
    .rst          (rst),
    .key          (key),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .core_ld      (core_ld),
    .core_key     (core_key),
    .core_text_in (core_text_in),
    .core_done    (core_done),
    .core_text_out(core_text_out),
    .err_clr      (err_clr),
    .err          (err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (core_ld) ld_cnt <= ld_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wd(input logic [127:0] b, input int i);
    return b[(3 - i) * 32 +: 32];
  endfunction

  task automatic push(input logic [31:0] w, input int gap);
    repeat (gap) begin
      chk("fill_no_ld", core_ld, 1'b0);
      tick();
    end
    chk("fill_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Called in the LOAD cycle; the core answers after lat WAIT cycles.
  task automatic core_respond(input int lat, input logic [127:0] ct);
    chk("load_ld", core_ld, 1'b1);
    chk("load_in_ready", in_ready, 1'b0);
    tick();
    chk("wait_ld_low", core_ld, 1'b0);
    repeat (lat - 1) begin
      chk("wait_in_ready", in_ready, 1'b0);
      chk("wait_out_valid", out_valid, 1'b0);
      tick();
    end
    core_done     = 1'b1;
    core_text_out = ct;
    tick();
    core_done     = 1'b0;
    core_text_out = '0;
  endtask

  task automatic drain(input logic [127:0] ct, input int stall);
    out_ready = 1'b0;
    repeat (stall) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, wd(ct, 0));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", out_valid, 1'b1);
      chk("drain_data", out_data, wd(ct, i));
      chk("drain_in_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("post_drain_valid", out_valid, 1'b0);
    chk("post_drain_in_ready", in_ready, 1'b1);
    chk("post_drain_busy", busy, 1'b0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_core_ld", core_ld, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_core_key", core_key, 128'h0);
    chk("rst_core_text", core_text_in, 128'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1'b1);

    // Stray core_done in FILL is ignored
    core_done     = 1'b1;
    core_text_out = Ct2;
    tick();
    core_done     = 1'b0;
    core_text_out = '0;
    tick();
    chk("stray_done_valid", out_valid, 1'b0);
    chk("stray_done_ready", in_ready, 1'b1);
    chk("stray_done_busy", busy, 1'b0);

    // FIPS-197 block with a 5-cycle output stall
    key     = FipsKey;
    ld_mark = ld_cnt;
    for (int i = 0; i < 4; i++) push(wd(FipsPt, i), 0);
    key = '0;
    chk("fips_text_in", core_text_in, FipsPt);
    chk("fips_key", core_key, FipsKey);
    core_respond(3, FipsCt);
    chk("fips_text_hold", core_text_in, FipsPt);
    drain(FipsCt, 5);
    chk("fips_one_ld", ld_cnt - ld_mark, 1);

    // Gapped input: words on cycles 0, 3, 4, 9
    key     = Key2;
    ld_mark = ld_cnt;
    push(wd(Pt2, 0), 0);
    chk("gap_busy", busy, 1'b1);
    push(wd(Pt2, 1), 2);
    push(wd(Pt2, 2), 0);
    push(wd(Pt2, 3), 4);
    key = '0;
    chk("gap_text_in", core_text_in, Pt2);
    chk("gap_key", core_key, Key2);
    // Upstream keeps offering while the block is in flight; none of it may be accepted
    in_valid = 1'b1;
    in_data  = 32'hbad0bad0;
    core_respond(6, Ct2);
    drain(Ct2, 0);
    in_valid = 1'b0;
    chk("gap_one_ld", ld_cnt - ld_mark, 1);

    // Reset after two words discards the partial block
    push(32'haaaaaaaa, 0);
    push(32'hbbbbbbbb, 0);
    chk("part_busy", busy, 1'b1);
    rst = 1'b0;
    tick();
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_text", core_text_in, 128'h0);
    chk("mid_rst_out_data", out_data, 32'h0);
    rst = 1'b1;
    tick();
    ld_mark = ld_cnt;
    key     = FipsKey;
    for (int i = 0; i < 3; i++) push(wd(FipsPt, i), 0);
    chk("no_ld_after_3", ld_cnt - ld_mark, 0);
    push(wd(FipsPt, 3), 0);
    key = '0;
    chk("re_text_in", core_text_in, FipsPt);
    core_respond(2, FipsCt);
    drain(FipsCt, 0);

    // Core never answers
    for (int i = 0; i < 4; i++) push(wd(Pt2, i), 0);
    chk("wd_ld", core_ld, 1'b1);
`ifdef AES_WORD_CTRL_WDOG_EN
    repeat (31) tick();
    chk("wd_err_pre", err, 1'b0);
    chk("wd_ready_pre", in_ready, 1'b0);
    tick();
    chk("wd_err_set", err, 1'b1);
    chk("wd_ready_post", in_ready, 1'b1);
    chk("wd_valid_post", out_valid, 1'b0);
    chk("wd_busy_post", busy, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_err_clr", err, 1'b0);
`else
    repeat (40) tick();
    chk("nowd_err", err, 1'b0);
    chk("nowd_ready", in_ready, 1'b0);
    chk("nowd_busy", busy, 1'b1);
    core_done     = 1'b1;
    core_text_out = Ct2;
    tick();
    core_done     = 1'b0;
    core_text_out = '0;
    drain(Ct2, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_word_ctrl.md
AES_WORD_CTRL -- requirements
Module: aes_word_ctrl

Interface
REQ-001 Parameter: WD_CYCLES, default 31, maximum cycles spent in WAIT before a watchdog abort (range 16..255).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset: synchronous, active-low.
REQ-004 key  input  128  cipher key, sampled when the block's fourth input word is accepted.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_data  input  32  upstream plaintext word; first word of a block is bits [127:96].
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_valid  output  1  ciphertext word valid.
REQ-009 out_data  output  32  ciphertext word; first word is bits [127:96].
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 core_ld  output  1  single-cycle load pulse to cipher core.
REQ-012 core_key  output  128  registered key to cipher core.
REQ-013 core_text_in  output  128  registered plaintext block to cipher core.
REQ-014 core_done  input  1  cipher core completion pulse.
REQ-015 core_text_out  input  128  cipher core result, valid in the core_done cycle.
REQ-016 err_clr  input  1  clears err.
REQ-017 err  output  1  sticky watchdog-abort flag.
REQ-018 busy  output  1  high in any state other than FILL with zero words held.

Function
REQ-019 States SHALL be FILL, LOAD, WAIT, DRAIN; 2-bit word counter wcnt.
REQ-020 FILL: in_ready=1; each in_valid&in_ready handshake stores in_data at word slot wcnt (slot 0 = [127:96]) and increments wcnt.
REQ-021 On the handshake with wcnt=3: core_text_in and core_key register simultaneously, wcnt wraps to 0, next state LOAD.
REQ-022 LOAD: core_ld=1 for exactly this one cycle, in_ready=0; next state WAIT unconditionally.
REQ-023 WAIT: in_ready=0; core_ld=0; core_text_in and core_key SHALL be held stable.
REQ-024 WAIT, core_done=1: core_text_out captured into output buffer, next state DRAIN.
REQ-025 core_done outside WAIT SHALL be ignored.
REQ-026 DRAIN: out_valid=1, out_data=buffer slot wcnt; on out_valid&out_ready wcnt increments; handshake at wcnt=3 returns to FILL with wcnt=0.
REQ-027 out_valid low with out_ready SHALL not advance; out_data stable while out_valid&!out_ready.
REQ-028 Latency: ld to first out_valid = core latency + 1 cycle; last input handshake to core_ld = 1 cycle.
REQ-029 Throughput: no overlap; next block's words are not accepted until DRAIN completes.
REQ-030 err_clr=1 clears err; a same-cycle set event takes priority over err_clr.

Reset
REQ-031 rst=0 at a clock edge SHALL force state FILL, wcnt=0, watchdog count=0, err=0, core_ld=0, out_valid=0, in_ready=0 during reset, out_data=0, core_text_in=0, core_key=0.
REQ-032 Reset mid-block SHALL discard partial input, pending core result, and undrained output; no core_ld after reset release until four new words arrive.

Configuration
REQ-033 Macro AES_WORD_CTRL_WDOG_EN defined: 8-bit counter cleared on WAIT entry, increments each WAIT cycle; reaching WD_CYCLES without core_done sets err, returns to FILL with wcnt=0, block discarded; core_done in the expiry cycle wins (normal DRAIN, err unchanged).
REQ-034 Macro undefined: no counter; WAIT waits indefinitely; err tied 0; WD_CYCLES unused.

Verification
REQ-035 FIPS-197: key 000102030405060708090a0b0c0d0e0f, words 00112233,44556677,8899aabb,ccddeeff, core model returns 69c4e0d86a7b0430d8cdb78070b4c55a -> out words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a in order, one core_ld pulse.
REQ-036 out_ready held 0 for 5 cycles in DRAIN -> out_valid stays 1, out_data stays 69c4e0d8, no word lost.
REQ-037 in_valid pulsed with gaps (words on cycles 0,3,4,9) -> core_ld exactly 1 cycle after cycle-9 handshake; in_ready=0 until DRAIN ends.
REQ-038 WDOG_EN, core_done never asserted -> err=1 after 31 WAIT cycles, in_ready=1 next cycle; err_clr -> err=0.
REQ-039 rst=0 after two words accepted -> all outputs reset values; subsequent four words produce normal result.
REQ-040 core_done injected in FILL -> ignored; no out_valid.
